// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order buffer of pipeline results that drains one write per cycle into the register file.
// Build option WB_FORWARD_EN adds two forwarding lookups over the queued entries.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [31:0]   in_data,
    input  logic          wb_stall,
    output logic [4:0]    writeRegister,
    output logic [31:0]   writeData,
    output logic          regWrite,
    output logic [31:0]   pending,
    output logic [AW:0]   count,
    input  logic [4:0]    fwd_reg1,
    input  logic [4:0]    fwd_reg2,
    output logic          fwd_hit1,
    output logic [31:0]   fwd_data1,
    output logic          fwd_hit2,
    output logic [31:0]   fwd_data2
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic [AW:0]      entryCount;
    logic [DEPTH-1:0] entryValid;
    logic [4:0]       entryReg  [DEPTH];
    logic [31:0]      entryData [DEPTH];
    logic [31:0]      entryMask [DEPTH];
    logic [31:0]      pendingAll;

    logic queueEmpty;
    logic queueFull;
    logic doPush;
    logic doPop;

    assign queueEmpty = (entryCount == '0);
    assign queueFull  = (entryCount == FULL_COUNT);
    assign in_ready   = !queueFull;

    // Writes to r0 complete the handshake but are dropped: r0 is hardwired zero in the file.
    assign doPush = in_valid && !queueFull && (in_reg != 5'd0);
    assign regWrite = !queueEmpty && !wb_stall;
    assign doPop    = regWrite;

    assign writeRegister = queueEmpty ? 5'd0  : entryReg[rdPtr];
    assign writeData     = queueEmpty ? 32'd0 : entryData[rdPtr];
    assign count         = entryCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            entryCount <= '0;
            entryValid <= '0;
        end else begin
            if (doPop) begin
                rdPtr             <= rdPtr + AW'(1);
                entryValid[rdPtr] <= 1'b0;
            end
            if (doPush) begin
                wrPtr             <= wrPtr + AW'(1);
                entryValid[wrPtr] <= 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   entryCount <= entryCount + (AW + 1)'(1);
                2'b01:   entryCount <= entryCount - (AW + 1)'(1);
                default: entryCount <= entryCount;
            endcase
        end
    end

    // Payload needs no reset; every read of it is qualified by a valid bit or count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            entryReg[wrPtr]  <= in_reg;
            entryData[wrPtr] <= in_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
            assign entryMask[gi] = entryValid[gi] ? (32'd1 << entryReg[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        pendingAll = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pendingAll = pendingAll | entryMask[i];
        end
    end

    assign pending = pendingAll & 32'hFFFF_FFFE;

`ifdef WB_FORWARD_EN
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match1[gi] = entryValid[gi] && (fwd_reg1 != 5'd0) && (entryReg[gi] == fwd_reg1);
            assign match2[gi] = entryValid[gi] && (fwd_reg2 != 5'd0) && (entryReg[gi] == fwd_reg2);
        end
    endgenerate

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = 32'd0;
        fwd_hit2  = 1'b0;
        fwd_data2 = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match1[rdPtr + AW'(i)]) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = entryData[rdPtr + AW'(i)];
            end
            if (match2[rdPtr + AW'(i)]) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = entryData[rdPtr + AW'(i)];
            end
        end
    end
`else
    logic unusedFwd;

    assign unusedFwd = ^{fwd_reg1, fwd_reg2};
    assign fwd_hit1  = 1'b0;
    assign fwd_data1 = 32'd0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: table-driven vectors plus a scoreboard of expected writes and a model register file.
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_reg = 5'd0;
    logic [31:0]   in_data = 32'd0;
    logic          wb_stall = 1'b0;
    logic [4:0]    writeRegister;
    logic [31:0]   writeData;
    logic          regWrite;
    logic [31:0]   pending;
    logic [AW:0]   count;
    logic [4:0]    fwd_reg1 = 5'd0;
    logic [4:0]    fwd_reg2 = 5'd0;
    logic          fwd_hit1;
    logic [31:0]   fwd_data1;
    logic          fwd_hit2;
    logic [31:0]   fwd_data2;

    reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .wb_stall(wb_stall),
        .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
        .pending(pending), .count(count),
        .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    typedef struct {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
        logic        stall;
        logic [2:0]  eCount;
        logic        eReady;
        logic        eRw;
        logic [4:0]  eWr;
        logic [31:0] eWd;
        logic [31:0] ePend;
    } vec_t;

    entry_t      sb[$];
    logic [31:0] dutFile   [32];
    logic [31:0] modelFile [32];
    logic [4:0]  fwdSel1 = 5'd0;
    logic [4:0]  fwdSel2 = 5'd0;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic v, input logic [4:0] r, input logic [31:0] d,
                                 input logic s, input logic [2:0] c, input logic rdy,
                                 input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic [31:0] pd);
        vec_t t;
        t.v = v; t.r = r; t.d = d; t.stall = s;
        t.eCount = c; t.eReady = rdy; t.eRw = rw; t.eWr = wr; t.eWd = wd; t.ePend = pd;
        return t;
    endfunction

    // One clock: drive at negedge, compare against the scoreboard just after, then retire/enqueue in the model.
    task automatic cycle(input logic v, input logic [4:0] r, input logic [31:0] d, input logic stall);
        logic [31:0] expPend;
        logic        expHit1;
        logic        expHit2;
        logic [31:0] expD1;
        logic [31:0] expD2;
        int          sizeBefore;
        entry_t      head;
        entry_t      e;
        @(negedge clk);
        in_valid = v; in_reg = r; in_data = d; wb_stall = stall;
        fwd_reg1 = fwdSel1; fwd_reg2 = fwdSel2;
        #1;
        expPend = 32'd0; expHit1 = 1'b0; expHit2 = 1'b0; expD1 = 32'd0; expD2 = 32'd0;
        sizeBefore = sb.size();
        foreach (sb[i]) begin
            expPend[sb[i].r] = 1'b1;
            if (fwdSel1 != 5'd0 && sb[i].r == fwdSel1) begin expHit1 = 1'b1; expD1 = sb[i].d; end
            if (fwdSel2 != 5'd0 && sb[i].r == fwdSel2) begin expHit2 = 1'b1; expD2 = sb[i].d; end
        end
        check("sb_count", 32'(count), 32'(sizeBefore));
        check("sb_in_ready", 32'(in_ready), 32'(sizeBefore < DEPTH));
        check("sb_pending", pending, expPend);
        check("sb_regWrite", 32'(regWrite), 32'(sizeBefore != 0 && !stall));
`ifdef WB_FORWARD_EN
        check("sb_fwd_hit1", 32'(fwd_hit1), 32'(expHit1));
        check("sb_fwd_data1", fwd_data1, expD1);
        check("sb_fwd_hit2", 32'(fwd_hit2), 32'(expHit2));
        check("sb_fwd_data2", fwd_data2, expD2);
`else
        check("sb_fwd_off", {fwd_hit1, fwd_hit2, 30'd0} | fwd_data1 | fwd_data2, 32'd0);
`endif
        if (regWrite) begin
            dutFile[writeRegister] = writeData;
            $display("write r%0d <= %h", writeRegister, writeData);
            if (sb.size() != 0) begin
                head = sb.pop_front();
                check("sb_writeRegister", 32'(writeRegister), 32'(head.r));
                check("sb_writeData", writeData, head.d);
                modelFile[head.r] = head.d;
            end
        end
        if (v && sizeBefore < DEPTH && r != 5'd0) begin
            e.r = r;
            e.d = d;
            sb.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            dutFile[i] = 32'd0;
            modelFile[i] = 32'd0;
        end
        //            v     reg    data            stall  cnt   rdy   rw    wr     wd             pending
        vecs[0]  = mkv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0);
        vecs[1]  = mkv(1'b0, 5'd0, 32'h0,        1'b0, 3'd1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h20);
        vecs[2]  = mkv(1'b0, 5'd0, 32'h0,        1'b1, 3'd0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0);
        vecs[3]  = mkv(1'b1, 5'd1, 32'h11,       1'b1, 3'd0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0);
        vecs[4]  = mkv(1'b1, 5'd2, 32'h22,       1'b1, 3'd1, 1'b1, 1'b0, 5'd1, 32'h11,       32'h02);
        vecs[5]  = mkv(1'b1, 5'd3, 32'h33,       1'b1, 3'd2, 1'b1, 1'b0, 5'd1, 32'h11,       32'h06);
        vecs[6]  = mkv(1'b1, 5'd4, 32'h44,       1'b1, 3'd3, 1'b1, 1'b0, 5'd1, 32'h11,       32'h0E);
        vecs[7]  = mkv(1'b1, 5'd9, 32'h99,       1'b1, 3'd4, 1'b0, 1'b0, 5'd1, 32'h11,       32'h1E);
        vecs[8]  = mkv(1'b1, 5'd9, 32'h99,       1'b0, 3'd4, 1'b0, 1'b1, 5'd1, 32'h11,       32'h1E);
        vecs[9]  = mkv(1'b0, 5'd0, 32'h0,        1'b0, 3'd3, 1'b1, 1'b1, 5'd2, 32'h22,       32'h1C);
        vecs[10] = mkv(1'b0, 5'd0, 32'h0,        1'b0, 3'd2, 1'b1, 1'b1, 5'd3, 32'h33,       32'h18);
        vecs[11] = mkv(1'b0, 5'd0, 32'h0,        1'b0, 3'd1, 1'b1, 1'b1, 5'd4, 32'h44,       32'h10);
        vecs[12] = mkv(1'b0, 5'd0, 32'h0,        1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0);
        vecs[13] = mkv(1'b1, 5'd0, 32'h1234,     1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0);
        vecs[14] = mkv(1'b0, 5'd0, 32'h0,        1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0);

        // Power-on reset state
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_count", 32'(count), 32'd0);
        check("reset_regWrite", 32'(regWrite), 32'd0);
        check("reset_pending", pending, 32'd0);
        check("reset_writeData", writeData, 32'd0);
        reset = 1'b0;

        // Single write, full/stall, zero register
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].stall);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].eCount));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].eReady));
            check($sformatf("vec%0d_regWrite", i), 32'(regWrite), 32'(vecs[i].eRw));
            check($sformatf("vec%0d_writeRegister", i), 32'(writeRegister), 32'(vecs[i].eWr));
            check($sformatf("vec%0d_writeData", i), writeData, vecs[i].eWd);
            check($sformatf("vec%0d_pending", i), pending, vecs[i].ePend);
        end
        check("file_r5", dutFile[5], 32'hDEADBEEF);
        check("file_r4", dutFile[4], 32'h44);
        check("file_r9", dutFile[9], 32'h0);
        check("file_r0", dutFile[0], 32'h0);

        // Same-register ordering with forwarding lookup on r7
        fwdSel1 = 5'd7;
        cycle(1'b1, 5'd7, 32'd1, 1'b1);
        cycle(1'b1, 5'd7, 32'd2, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1);
        check("pend7_two", 32'(pending[7]), 32'd1);
`ifdef WB_FORWARD_EN
        check("fwd7_youngest", fwd_data1, 32'd2);
`endif
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        check("pend7_one", 32'(pending[7]), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        check("pend7_none", 32'(pending[7]), 32'd0);
        check("file_r7", dutFile[7], 32'd2);
        fwdSel1 = 5'd0;

        // Reset mid-burst with three entries queued
        cycle(1'b1, 5'd10, 32'hA0A0, 1'b1);
        cycle(1'b1, 5'd11, 32'hB1B1, 1'b1);
        cycle(1'b1, 5'd12, 32'hC2C2, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; wb_stall = 1'b0; reset = 1'b1;
        #1;
        check("midreset_regWrite", 32'(regWrite), 32'd0);
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_pending", pending, 32'd0);
        check("midreset_writeRegister", 32'(writeRegister), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0);
        check("midreset_r10", dutFile[10], 32'd0);
        check("midreset_r12", dutFile[12], 32'd0);

        // Throughput: one push per cycle, queue never builds up
        for (int i = 0; i < 20; i++) begin
            fwdSel1 = 5'($urandom_range(0, 31));
            fwdSel2 = 5'($urandom_range(0, 31));
            cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
            check("thru_count_le1", 32'(count <= 1), 32'd1);
        end
        for (int i = 0; i < 8 && sb.size() != 0; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0);
        check("thru_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("file_match_r%0d", i), dutFile[i], modelFile[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
